// File: rtl/imem_loader.sv
// imem_loader: writes 32-bit words big-endian as four byte writes into instruction memory.
// Optional IMEM_LOADER_CHECKSUM_EN adds a per-session 32-bit word checksum.
module imem_loader #(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = $clog2(MEM_BYTES)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [31:0]       word_in,
  input  logic              word_valid,
  input  logic              word_last,
  output logic              word_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W-2:0] words_written,
  output logic [31:0]       checksum
);
  typedef enum logic [1:0] {IDLE, ARMED, WRITE, DONE} state_t;
  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_idx;
  logic [31:0]       r_word;
  logic              r_last;
  logic [1:0]        w_next_idx;
  logic [31:0]       w_shift;
  logic              w_accept;
  assign w_next_idx = r_idx + 2'd1;
  assign w_shift    = r_word << {w_next_idx, 3'b000};
  assign w_accept   = word_valid && word_ready;
  // mem_* are loaded one edge ahead so byte k is on the bus while r_idx == k
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      r_state       <= IDLE;
      r_addr        <= '0;
      r_idx         <= '0;
      r_word        <= '0;
      r_last        <= 1'b0;
      word_ready    <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      overflow      <= 1'b0;
      words_written <= '0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_addr        <= base_addr & ~ADDR_W'(3);
          words_written <= '0;
          overflow      <= 1'b0;
          word_ready    <= 1'b1;
          busy          <= 1'b1;
          r_state       <= ARMED;
        end
        ARMED: if (w_accept) begin
          r_word     <= word_in;
          r_last     <= word_last;
          r_idx      <= '0;
          word_ready <= 1'b0;
          mem_we     <= 1'b1;
          mem_addr   <= r_addr;
          mem_wdata  <= word_in[31:24];
          r_state    <= WRITE;
        end
        WRITE: if (r_idx != 2'd3) begin
          r_idx     <= w_next_idx;
          mem_addr  <= r_addr + ADDR_W'(w_next_idx);
          mem_wdata <= w_shift[31:24];
        end else begin
          mem_we        <= 1'b0;
          r_addr        <= r_addr + ADDR_W'(4);
          words_written <= words_written + (ADDR_W-1)'(1);
          if (r_last) begin
            done    <= 1'b1;
            r_state <= DONE;
          end else if (r_addr == ADDR_W'(MEM_BYTES-4)) begin
            overflow <= 1'b1;
            done     <= 1'b1;
            r_state  <= DONE;
          end else begin
            word_ready <= 1'b1;
            r_state    <= ARMED;
          end
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] r_checksum;
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) r_checksum <= '0;
    else if (r_state == IDLE && start) r_checksum <= '0;
    else if (w_accept) r_checksum <= r_checksum + word_in;
  assign checksum = r_checksum;
`else
  assign checksum = 32'h0;
`endif
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard bench; expected byte writes are queued when a word is driven.
module tb_imem_loader;
  localparam int AW = 10;
  logic          CLK = 1'b0, RESET = 1'b1, start = 1'b0, word_valid = 1'b0, word_last = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [31:0]   word_in = '0;
  logic          word_ready, mem_we, busy, done, overflow;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic [AW-2:0] words_written;
  logic [31:0]   checksum;
  int            n_cmp = 0, n_err = 0;
  logic [17:0]   q[$];
  logic [17:0]   m_e;
  logic [AW-1:0] m_addr = '0;
  int            m_ws = 0;
  logic [31:0]   m_ck = '0;

  always #5 CLK = ~CLK;

  imem_loader dut (
    .CLK(CLK), .RESET(RESET), .start(start), .base_addr(base_addr),
    .word_in(word_in), .word_valid(word_valid), .word_last(word_last),
    .word_ready(word_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .busy(busy), .done(done), .overflow(overflow),
    .words_written(words_written), .checksum(checksum)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_ck();
`ifdef IMEM_LOADER_CHECKSUM_EN
    return m_ck;
`else
    return 32'h0;
`endif
  endfunction

  always @(negedge CLK)
    if (!RESET && mem_we) begin
      chk("rdy_in_write", word_ready, 0);
      if (q.size() == 0) chk("we_unexpected", 1, 0);
      else begin
        m_e = q.pop_front();
        chk("wr_byte", {mem_addr, mem_wdata}, m_e);
      end
    end

  task automatic do_start(input logic [AW-1:0] b, input logic wv);
    @(posedge CLK); #1;
    start = 1'b1; base_addr = b; word_valid = wv; word_in = 32'hDEADBEEF; word_last = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0; word_valid = 1'b0;
    m_addr = b & ~AW'(3); m_ws = 0; m_ck = '0;
    @(negedge CLK);
    chk("start_busy", busy, 1);
    chk("start_rdy", word_ready, 1);
    chk("start_ovf", overflow, 0);
    chk("start_ws", words_written, 0);
    chk("start_ck", checksum, 0);
    chk("start_we", mem_we, 0);
  endtask

  task automatic send(input logic [31:0] w, input logic last, input int gap);
    bit ovf;
    int k;
    ovf = !last && (m_addr == AW'(1020));
    for (int i = 0; i < 4; i++) q.push_back({m_addr + AW'(i), w[31-8*i -: 8]});
    repeat (gap) @(negedge CLK);
    word_in = w; word_last = last; word_valid = 1'b1;
    k = 0;
    while (!word_ready && k < 50) begin @(negedge CLK); k++; end
    if (!word_ready) begin
      chk("rdy_timeout", 0, 1);
      word_valid = 1'b0;
      q.delete();
      return;
    end
    @(posedge CLK); #1;
    word_valid = 1'b0;
    m_ck += w; m_ws++; m_addr += AW'(4);
    repeat (4) begin @(negedge CLK); chk("we_on", mem_we, 1); end
    @(negedge CLK);
    if (last || ovf) begin
      chk("done_pulse", done, 1);
      chk("ws", words_written, m_ws);
      chk("ovf", overflow, ovf);
      chk("checksum", checksum, exp_ck());
      @(negedge CLK);
      chk("done_one_cycle", done, 0);
      chk("idle_busy", busy, 0);
    end else chk("rdy_back", word_ready, 1);
  endtask

  initial begin
    @(negedge CLK);
    chk("rst_we", mem_we, 0);
    chk("rst_rdy", word_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_data", mem_wdata, 0);
    chk("rst_ws", words_written, 0);
    chk("rst_ck", checksum, 0);
    RESET = 1'b0;
    // basic single word
    do_start(0, 0);
    send(32'h08011020, 1, 0);
    // misaligned base, gap between words
    do_start(10'h006, 0);
    send(32'h00642824, 0, 0);
    send(32'h05274025, 1, 2);
    // end of memory
    do_start(10'h3FC, 0);
    send(32'h11111111, 0, 0);
    word_in = 32'h22222222; word_last = 1'b1; word_valid = 1'b1;
    repeat (6) begin @(negedge CLK); chk("no_accept", word_ready, 0); end
    word_valid = 1'b0;
    chk("ovf_sticky", overflow, 1);
    chk("ovf_ws", words_written, 1);
    // async reset mid-word
    do_start(0, 0);
    send(32'h9ABCDEF0, 0, 0);
    q.push_back({m_addr, 8'hA1});
    q.push_back({m_addr + AW'(1), 8'hB2});
    word_in = 32'hA1B2C3D4; word_last = 1'b1; word_valid = 1'b1;
    @(posedge CLK); #1;
    word_valid = 1'b0;
    @(negedge CLK); @(negedge CLK);
    @(posedge CLK); #1;
    chk("b2_we", mem_we, 1);
    chk("b2_data", {mem_addr, mem_wdata}, {m_addr + AW'(2), 8'hC3});
    chk("pre_rst_ws", words_written, 1);
    RESET = 1'b1;
    #1;
    chk("arst_we", mem_we, 0);
    chk("arst_busy", busy, 0);
    chk("arst_ws", words_written, 0);
    chk("arst_done", done, 0);
    q.delete();
    @(negedge CLK);
    RESET = 1'b0;
    do_start(0, 0);
    send(32'h13572468, 1, 0);
    // start while armed is ignored
    do_start(0, 0);
    start = 1'b1; base_addr = 10'h100;
    @(negedge CLK);
    start = 1'b0;
    send(32'hCAFEF00D, 1, 0);
    // checksum sessions; second start arrives together with word_valid
    do_start(0, 0);
    send(32'h00000001, 0, 0);
    send(32'hFFFFFFFF, 1, 0);
    do_start(10'h040, 1);
    send(32'h00000003, 0, 1);
    send(32'h00000004, 1, 0);
    repeat (3) @(negedge CLK);
    chk("q_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
